// File: rtl/reg_dump_sequencer_pkg.sv
// Shared debug definitions: dump FSM encoding, frame constants and the
// UART command bytes understood by the debug FSM.
package reg_dump_sequencer_pkg;

  // Register-dump FSM states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_ADDR = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOAD = 3'd4,
    ST_BYTE = 3'd5,
    ST_TRL  = 3'd6,
    ST_DONE = 3'd7
  } dump_state_t;

  // First byte of every dump frame ('R')
  localparam logic [7:0] DBG_HEADER_BYTE = 8'h52;

  // Frame length for a full register bank: header + 4 bytes per word + checksum
  localparam int DBG_DEFAULT_NUM_REGS = 32;
  localparam int DBG_FRAME_LEN        = 4 * DBG_DEFAULT_NUM_REGS + 2;

  // UART command bytes decoded by the debug FSM
  localparam logic [7:0] CMD_DUMP_REGS = 8'h44;  // 'D': dump register bank
  localparam logic [7:0] CMD_DUMP_PIPE = 8'h50;  // 'P': dump pipeline latches
  localparam logic [7:0] CMD_PING      = 8'h3F;  // '?': liveness probe
  localparam logic [7:0] CMD_ACK       = 8'h06;  // reply to a ping

  // Frame length for an arbitrary number of dumped words
  function automatic int frame_len(input int num_regs);
    return 4 * num_regs + 2;
  endfunction

endpackage

// File: rtl/reg_dump_sequencer_byte_serializer.sv
// Holds one 32-bit word and hands it out as 4 bytes, MSB first. A byte is
// consumed (fire) only in cycles where the consumer is enabled and not full.
module byte_serializer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        enable,
  input  logic        full,
  output logic [7:0]  byte_out,
  output logic        fire,
  output logic        last_byte
);

  logic [31:0] word_reg;
  logic [1:0]  idx_reg;
  logic [7:0]  byte_lane [4];

  // Lane 0 is the most significant byte
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = word_reg[31 - 8*gi -: 8];
  end

  assign byte_out  = byte_lane[idx_reg];
  assign fire      = enable & ~full;
  assign last_byte = (idx_reg == 2'd3);

  // Capture a new word, or step to the next byte when one is consumed
  always_ff @(posedge clock) begin
    if (reset) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else if (load) begin
      word_reg <= word_in;
      idx_reg  <= '0;
    end else if (fire) begin
      idx_reg  <= idx_reg + 2'd1;
    end
  end

endmodule

// File: rtl/reg_dump_sequencer.sv
// Streams every register of the bank over the UART TX FIFO as one frame:
// header byte, each word MSB first, then an XOR checksum of the data bytes.
module reg_dump_sequencer
  import reg_dump_sequencer_pkg::*;
#(
  parameter int         NUM_REGS    = 32,
  parameter int         ADDR_W      = 5,
  parameter int         READ_LAT    = 1,
  parameter logic [7:0] HEADER_BYTE = DBG_HEADER_BYTE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] readAddrFromBank,
  input  logic [31:0]       readDataFromRegs,
  output logic [7:0]        dataToUartOutFifo,
  output logic              writeFifoFlag,
  input  logic              txFifoFull
);

  // Termination is by compare against the last index, never by wrap-around
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [1:0]        WAIT_LAST = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  dump_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        wait_reg, wait_next;
  logic [7:0]        chk_reg, chk_next;
  logic [7:0]        data_reg, data_next;
  logic              wr_reg, wr_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;

  logic              ser_load;
  logic              ser_en;
  logic              ser_fire;
  logic              ser_last;
  logic [7:0]        ser_byte;

  // Abort wins over loading or emitting in the same cycle
  assign ser_load = (state_reg == ST_LOAD) && !abort;
  assign ser_en   = (state_reg == ST_BYTE) && !abort;

  byte_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (ser_load),
    .word_in   (readDataFromRegs),
    .enable    (ser_en),
    .full      (txFifoFull),
    .byte_out  (ser_byte),
    .fire      (ser_fire),
    .last_byte (ser_last)
  );

  // State, counters, checksum and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      wait_reg  <= '0;
      chk_reg   <= '0;
      data_reg  <= '0;
      wr_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      wait_reg  <= wait_next;
      chk_reg   <= chk_next;
      data_reg  <= data_next;
      wr_reg    <= wr_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state and next-output decode; FIFO full is checked in the decision cycle
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    addr_next  = addr_reg;
    wait_next  = wait_reg;
    chk_next   = chk_reg;
    data_next  = data_reg;
    wr_next    = 1'b0;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (state_reg != ST_IDLE && abort) begin
      state_next = ST_IDLE;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            state_next = ST_HDR;
            busy_next  = 1'b1;
            chk_next   = '0;
            idx_next   = '0;
          end
        end
        ST_HDR: begin
          if (!txFifoFull) begin
            wr_next    = 1'b1;
            data_next  = HEADER_BYTE;
            state_next = ST_ADDR;
          end
        end
        ST_ADDR: begin
          addr_next  = idx_reg;
          wait_next  = '0;
          state_next = (READ_LAT == 0) ? ST_LOAD : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_reg == WAIT_LAST) begin
            state_next = ST_LOAD;
          end else begin
            wait_next = wait_reg + 2'd1;
          end
        end
        ST_LOAD: begin
          state_next = ST_BYTE;
        end
        ST_BYTE: begin
          if (ser_fire) begin
            wr_next   = 1'b1;
            data_next = ser_byte;
            chk_next  = chk_reg ^ ser_byte;
            if (ser_last) begin
              if (idx_reg == LAST_IDX) begin
                state_next = ST_TRL;
              end else begin
                idx_next   = idx_reg + ADDR_W'(1);
                state_next = ST_ADDR;
              end
            end
          end
        end
        ST_TRL: begin
          if (!txFifoFull) begin
            wr_next    = 1'b1;
            data_next  = chk_reg;
            state_next = ST_DONE;
          end
        end
        ST_DONE: begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign readAddrFromBank  = addr_reg;
  assign dataToUartOutFifo = data_reg;
  assign writeFifoFlag     = wr_reg;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: a 4-register / latency-1 instance for the
// directed and randomized frame tests, plus two full-size instances with
// read latency 0 and 3 for frame length, address order and latency.
module tb_reg_dump_sequencer;

  logic   clock = 1'b0;
  logic   reset;
  longint cycle = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // ---------------- instance A: NUM_REGS=4, READ_LAT=1 ----------------
  logic        start_a, abort_a, full_a;
  logic        busy_a, done_a, wr_a;
  logic [4:0]  addr_a, hist_a1;
  logic [31:0] rdata_a;
  logic [7:0]  data_a;
  logic [31:0] regs_a [4];

  reg_dump_sequencer #(.NUM_REGS(4), .ADDR_W(5), .READ_LAT(1), .HEADER_BYTE(8'h52)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .readAddrFromBank(addr_a),
    .readDataFromRegs(rdata_a), .dataToUartOutFifo(data_a),
    .writeFifoFlag(wr_a), .txFifoFull(full_a)
  );

  // Bank model: data follows the address one cycle later
  always @(posedge clock) hist_a1 <= addr_a;
  assign rdata_a = regs_a[hist_a1[1:0]];

  // ---------------- instance B: 32 regs, READ_LAT=0 ----------------
  logic        start_b, abort_b, full_b;
  logic        busy_b, done_b, wr_b;
  logic [4:0]  addr_b;
  logic [31:0] rdata_b;
  logic [7:0]  data_b;

  reg_dump_sequencer #(.NUM_REGS(32), .ADDR_W(5), .READ_LAT(0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .readAddrFromBank(addr_b),
    .readDataFromRegs(rdata_b), .dataToUartOutFifo(data_b),
    .writeFifoFlag(wr_b), .txFifoFull(full_b)
  );

  assign rdata_b = {27'd0, addr_b};

  // ---------------- instance C: 32 regs, READ_LAT=3 ----------------
  logic        start_c, abort_c, full_c;
  logic        busy_c, done_c, wr_c;
  logic [4:0]  addr_c, hist_c1, hist_c2, hist_c3;
  logic [31:0] rdata_c;
  logic [7:0]  data_c;

  reg_dump_sequencer #(.NUM_REGS(32), .ADDR_W(5), .READ_LAT(3)) dut_c (
    .clock(clock), .reset(reset), .start(start_c), .abort(abort_c),
    .busy(busy_c), .done(done_c), .readAddrFromBank(addr_c),
    .readDataFromRegs(rdata_c), .dataToUartOutFifo(data_c),
    .writeFifoFlag(wr_c), .txFifoFull(full_c)
  );

  always @(posedge clock) begin
    hist_c1 <= addr_c;
    hist_c2 <= hist_c1;
    hist_c3 <= hist_c2;
  end
  assign rdata_c = {27'd0, hist_c3};

  // ---------------- capture / scoreboard state ----------------
  logic [7:0] cap_a[$], cap_b[$], cap_c[$];
  logic [4:0] addr_q_b[$], addr_q_c[$];
  logic [7:0] exp_q[$];
  int         dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;
  logic       full_prev_a = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) full_prev_a <= full_a;

  // Monitors: record written bytes, done pulses and issued addresses
  always @(negedge clock) begin
    if (wr_a) begin
      cap_a.push_back(data_a);
      chk("write_while_full_a", {63'd0, full_prev_a}, 64'd0);
    end
    if (done_a) dcnt_a++;
    if (wr_b) cap_b.push_back(data_b);
    if (done_b) dcnt_b++;
    if (wr_c) cap_c.push_back(data_c);
    if (done_c) dcnt_c++;
    if (busy_b && (addr_q_b.size() == 0 || addr_q_b[$] != addr_b)) addr_q_b.push_back(addr_b);
    if (busy_c && (addr_q_c.size() == 0 || addr_q_c[$] != addr_c)) addr_q_c.push_back(addr_c);
  end

  // Advance to just after the next falling edge (after the monitors)
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Reference frame: header, each word MSB first, XOR of the data bytes
  task automatic build_exp(input int n, input int which);
    logic [7:0]  x;
    logic [31:0] w;
    logic [7:0]  b;
    exp_q.delete();
    exp_q.push_back(8'h52);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = (which == 0) ? regs_a[i] : 32'(i);
      for (int k = 0; k < 4; k++) begin
        b = 8'((w >> (24 - 8 * k)) & 32'hFF);
        x = x ^ b;
        exp_q.push_back(b);
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic compare_frame(input string tag, input int which, input int n);
    logic [7:0] got[$];
    build_exp(n, which);
    if (which == 0) got = cap_a;
    else if (which == 1) got = cap_b;
    else got = cap_c;
    chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {56'd0, got[i]}, {56'd0, exp_q[i]});
  endtask

  task automatic pulse_start_a(output longint t0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    t0 = cycle;
  endtask

  task automatic wait_done_a(input string tag, input int budget, output longint t_done);
    t_done = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_a) begin
        t_done = cycle;
        break;
      end
    end
    if (t_done < 0) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_bytes_a(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cap_a.size() >= n) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) chk({tag, "_bytes_timeout"}, 64'(cap_a.size()), 64'(n));
  endtask

  task automatic clear_a();
    cap_a.delete();
    dcnt_a = 0;
  endtask

  initial begin
    longint t0, td, tb_done, tc_done;
    reset = 1'b1;
    {start_a, abort_a, full_a} = 3'b000;
    {start_b, abort_b, full_b} = 3'b000;
    {start_c, abort_c, full_c} = 3'b000;
    regs_a[0] = 32'h11223344;
    regs_a[1] = 32'h00000000;
    regs_a[2] = 32'hFFFFFFFF;
    regs_a[3] = 32'h00000005;
    repeat (3) step();

    // Reset values
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_done", {63'd0, done_a}, 64'd0);
    chk("rst_wr",   {63'd0, wr_a},   64'd0);
    chk("rst_data", {56'd0, data_a}, 64'd0);
    chk("rst_addr", {59'd0, addr_a}, 64'd0);
    reset = 1'b0;
    step();
    $display("reset released at cycle %0d", cycle);

    // Plain frame, FIFO never full
    clear_a();
    pulse_start_a(t0);
    chk("t1_busy_after_start", {63'd0, busy_a}, 64'd1);
    wait_done_a("t1", 100, td);
    chk("t1_latency", 64'(td - t0), 64'd31);
    repeat (3) step();
    compare_frame("t1", 0, 4);
    chk("t1_done_count", 64'(dcnt_a), 64'd1);
    chk("t1_busy_after", {63'd0, busy_a}, 64'd0);
    $display("t1 frame: %0d bytes, latency %0d", cap_a.size(), td - t0);

    // Five-cycle stall inside word 2
    clear_a();
    pulse_start_a(t0);
    wait_bytes_a("t2", 10);
    full_a = 1'b1;
    repeat (5) step();
    full_a = 1'b0;
    wait_done_a("t2", 100, td);
    chk("t2_latency", 64'(td - t0), 64'd36);
    repeat (3) step();
    compare_frame("t2", 0, 4);
    chk("t2_done_count", 64'(dcnt_a), 64'd1);
    $display("t2 frame with stall: %0d bytes, latency %0d", cap_a.size(), td - t0);

    // Abort after seven bytes
    clear_a();
    pulse_start_a(t0);
    wait_bytes_a("t3", 7);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    chk("t3_wr_after_abort",   {63'd0, wr_a},   64'd0);
    chk("t3_busy_after_abort", {63'd0, busy_a}, 64'd0);
    repeat (20) step();
    chk("t3_bytes_after_abort", 64'(cap_a.size()), 64'd7);
    chk("t3_no_done", 64'(dcnt_a), 64'd0);
    build_exp(4, 0);
    for (int i = 0; i < 7 && i < cap_a.size(); i++)
      chk($sformatf("t3_prefix%0d", i), {56'd0, cap_a[i]}, {56'd0, exp_q[i]});
    $display("t3 aborted after %0d bytes", cap_a.size());
    clear_a();
    pulse_start_a(t0);
    wait_done_a("t3r", 100, td);
    chk("t3r_latency", 64'(td - t0), 64'd31);
    repeat (3) step();
    compare_frame("t3r", 0, 4);
    chk("t3r_done_count", 64'(dcnt_a), 64'd1);
    $display("t3 restart frame: %0d bytes", cap_a.size());

    // Reset in the middle of a word
    clear_a();
    pulse_start_a(t0);
    wait_bytes_a("t4", 6);
    reset = 1'b1;
    step();
    chk("t4_rst_busy", {63'd0, busy_a}, 64'd0);
    chk("t4_rst_done", {63'd0, done_a}, 64'd0);
    chk("t4_rst_wr",   {63'd0, wr_a},   64'd0);
    chk("t4_rst_data", {56'd0, data_a}, 64'd0);
    chk("t4_rst_addr", {59'd0, addr_a}, 64'd0);
    reset = 1'b0;
    step();
    $display("t4 mid-word reset cleared outputs");

    // Start pulsed while busy is ignored
    clear_a();
    pulse_start_a(t0);
    wait_bytes_a("t4s", 5);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    wait_done_a("t4s", 100, td);
    chk("t4s_latency", 64'(td - t0), 64'd31);
    repeat (5) step();
    compare_frame("t4s", 0, 4);
    chk("t4s_done_count", 64'(dcnt_a), 64'd1);
    $display("t4 frame with extra start: %0d bytes", cap_a.size());

    // Random register contents under random backpressure
    for (int r = 0; r < 3; r++) begin
      bit got_done;
      for (int i = 0; i < 4; i++) regs_a[i] = $urandom;
      clear_a();
      pulse_start_a(t0);
      got_done = 1'b0;
      for (int i = 0; i < 300; i++) begin
        full_a = ($urandom_range(0, 3) == 0);
        step();
        if (done_a) begin
          got_done = 1'b1;
          break;
        end
      end
      full_a = 1'b0;
      chk($sformatf("rnd%0d_done_seen", r), {63'd0, got_done}, 64'd1);
      repeat (3) step();
      compare_frame($sformatf("rnd%0d", r), 0, 4);
      chk($sformatf("rnd%0d_done_count", r), 64'(dcnt_a), 64'd1);
      $display("rnd%0d frame: %0d bytes regs %h %h %h %h", r, cap_a.size(),
               regs_a[0], regs_a[1], regs_a[2], regs_a[3]);
    end

    // Full-size frames with read latency 0 and 3
    cap_b.delete(); cap_c.delete();
    addr_q_b.delete(); addr_q_c.delete();
    dcnt_b = 0; dcnt_c = 0;
    start_b = 1'b1;
    start_c = 1'b1;
    step();
    start_b = 1'b0;
    start_c = 1'b0;
    t0 = cycle;
    tb_done = -1;
    tc_done = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (done_b && tb_done < 0) tb_done = cycle;
      if (done_c && tc_done < 0) tc_done = cycle;
      if (tb_done >= 0 && tc_done >= 0) break;
    end
    chk("t5b_latency", 64'(tb_done - t0), 64'd195);
    chk("t5c_latency", 64'(tc_done - t0), 64'd291);
    repeat (3) step();
    compare_frame("t5b", 1, 32);
    compare_frame("t5c", 2, 32);
    chk("t5b_done_count", 64'(dcnt_b), 64'd1);
    chk("t5c_done_count", 64'(dcnt_c), 64'd1);
    chk("t5b_addr_count", 64'(addr_q_b.size()), 64'd32);
    chk("t5c_addr_count", 64'(addr_q_c.size()), 64'd32);
    for (int i = 0; i < 32 && i < addr_q_b.size(); i++)
      chk($sformatf("t5b_addr%0d", i), {59'd0, addr_q_b[i]}, 64'(i));
    for (int i = 0; i < 32 && i < addr_q_c.size(); i++)
      chk($sformatf("t5c_addr%0d", i), {59'd0, addr_q_c[i]}, 64'(i));
    $display("t5 frames: lat0 %0d bytes in %0d cycles, lat3 %0d bytes in %0d cycles",
             cap_b.size(), tb_done - t0, cap_c.size(), tc_done - t0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_sequencer.md
Name: reg_dump_sequencer

Overview:
Controller that takes the register bank's debug read port and streams every register over UART as one framed dump. It sequences the read address, waits the bank's read latency, and latches each 32-bit word. It then pushes the word MSB-first into the UART TX FIFO, honouring FIFO-full backpressure. It sits between the debug FSM (start/done handshake), the register bank debug port and the UART TX FIFO write side.

Parameters:
NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1); must be 1..32
ADDR_W, 5, register address width
READ_LAT, 1, cycles from readAddr change to valid readData; 0..3
HEADER_BYTE, 8'h52, first byte of every frame ('R')

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a dump
abort  in  1  level: cancel the dump in progress
busy  out  1  high from the cycle after start is accepted until done or abort
done  out  1  one-cycle pulse after the trailer byte is written
readAddrFromBank  out  ADDR_W  register bank debug read address
readDataFromRegs  in  32  register bank debug read data
dataToUartOutFifo  out  8  byte to the TX FIFO
writeFifoFlag  out  1  TX FIFO write strobe, one byte per high cycle
txFifoFull  in  1  TX FIFO full; no write may be issued while high

Behaviour:
- Reset values: busy=0, done=0, writeFifoFlag=0, dataToUartOutFifo=0, readAddrFromBank=0, checksum=0, state IDLE.
- All outputs are registered. Write strobe and data change together.
- Frame format: HEADER_BYTE, then NUM_REGS words (4 bytes each, [31:24] first), then one checksum byte.
- The checksum is the XOR of all 4*NUM_REGS data bytes; the header is excluded. Frame length is 4*NUM_REGS+2 bytes (130 at default).
- FSM states: IDLE, HDR, ADDR, WAIT, LOAD, BYTE, TRL, DONE.
- IDLE:
  - start=1 -> HDR, busy=1, checksum cleared, address counter cleared.
  - start while busy is ignored.
- HDR: when txFifoFull=0, write HEADER_BYTE for one cycle -> ADDR. Otherwise hold with no write.
- ADDR: drive readAddrFromBank=index, clear the wait counter -> WAIT.
- WAIT: count READ_LAT cycles, then -> LOAD. With READ_LAT=0, WAIT lasts 0 cycles and ADDR goes directly to LOAD.
- LOAD: latch readDataFromRegs into the word register, byteIdx=0 -> BYTE.
- BYTE:
  - Each cycle with txFifoFull=0: write word byte byteIdx (MSB first), XOR it into the checksum, increment byteIdx.
  - txFifoFull=1: writeFifoFlag=0 and all state is held.
  - After byte 3: if index==NUM_REGS-1 -> TRL; else index+1 -> ADDR.
- TRL: when not full, write the checksum byte -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- Backpressure is sampled in the same cycle as the write decision. A write is never asserted in a cycle where txFifoFull=1.
- abort=1 in any non-IDLE state: next cycle state IDLE, busy=0, writeFifoFlag=0, no done. Bytes already written stay in the FIFO. abort has priority over a simultaneous start.
- start and abort asserted together in IDLE: start is ignored.
- Reset mid-operation returns every output to its reset value next cycle.
- The index counter never wraps. NUM_REGS=32 is terminated by comparison to NUM_REGS-1, not by overflow.
- Minimum frame latency with FIFO never full: start to done = 1 + NUM_REGS*(6+READ_LAT) + 1 + 1 cycles.
- readAddrFromBank holds its last value while IDLE.

Decomposition:
- Shared debug package: FSM state encoding (3-bit localparams), HEADER_BYTE value, frame-length constant.
- The UART command byte constants used by the debug FSM go in the same package.
- Sub-module byte_serializer: loads a 32-bit word and emits 4 bytes MSB-first under a ready/valid-style full signal. It is reused for the pipeline-latch dump.
- The sequencer holds the FSM, the address/wait counters and the checksum.

Test Plan:
1. NUM_REGS=4, READ_LAT=1, regs={32'h11223344, 0, 32'hFFFFFFFF, 32'h00000005}, FIFO never full, pulse start -> 18 bytes 52 11 22 33 44 00 00 00 00 FF FF FF FF 00 00 00 05 checksum; done exactly once; busy low afterwards.
2. Same as 1, txFifoFull held high for 5 cycles in the middle of word 2 -> no write during stall; byte stream identical to 1; done delayed by exactly 5 cycles.
3. abort pulsed after 7 bytes written -> writes stop next cycle, busy=0, no done. A new start then produces a complete, correct frame beginning with 52.
4. reset asserted mid-word -> all outputs 0 next cycle. start pulsed during busy -> ignored, frame length unchanged.
5. Default parameters, regs[i]=i, READ_LAT=0 and READ_LAT=3 -> 130 bytes each; addresses 0..31 each issued once; start-to-done = 195 cycles and 291 cycles respectively.
